// File: rtl/arith_pkg.sv
// Shared definitions for the lab arithmetic blocks: the default operand width
// and the sequencing state encodings used by the bit-serial datapaths.
package arith_pkg;

    localparam int ARITH_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bit counter width; a one-bit datapath still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell computing a - b - bin, the counterpart of the
// one-bit full-adder cell used by the parallel adders.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: a - b - bin one bit per clock, LSB first,
// through a single full_sub cell, with a start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start; operands are latched on the accepting edge
// RUN     | one bit per edge; results registered when the last bit is done
// DONE    | done pulse for one cycle, results valid, then back to IDLE
module sub_serial
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [WIDTH-1:0] borrows
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_w_q, diff_w_d;
    logic [WIDTH-1:0] borrows_w_q, borrows_w_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [WIDTH-1:0] borrows_q, borrows_d;
    logic             cell_d, cell_bo;

    full_sub u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (brw_q),
        .diff (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        brw_d       = brw_q;
        diff_w_d    = diff_w_q;
        borrows_w_d = borrows_w_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        borrows_d   = borrows_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    a_sr_d      = a;
                    b_sr_d      = b;
                    brw_d       = bin;
                    cnt_d       = '0;
                    diff_w_d    = '0;
                    borrows_w_d = '0;
                end
            end
            ST_RUN: begin
                // Diff bits enter from the MSB so bit 0 lands at position 0 after WIDTH shifts.
                diff_w_d           = diff_w_q >> 1;
                diff_w_d[WIDTH-1]  = cell_d;
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        borrows_w_d[i] = cell_bo;
                    end
                end
                brw_d  = cell_bo;
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = ST_DONE;
                    diff_d    = diff_w_d;
                    bout_d    = cell_bo;
                    borrows_d = borrows_w_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            brw_q       <= 1'b0;
            diff_w_q    <= '0;
            borrows_w_q <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            borrows_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            brw_q       <= brw_d;
            diff_w_q    <= diff_w_d;
            borrows_w_q <= borrows_w_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            borrows_q   <= borrows_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign diff    = diff_q;
    assign bout    = bout_q;
    assign borrows = borrows_q;

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial at WIDTH = 3: directed vector table, handshake corner
// sequences and random operands checked against an arithmetic reference.
module tb_sub_serial;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff, borrows;
    logic         bout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_diff, prev_brw;
    logic         prev_bout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic [W-1:0] brw;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    sub_serial #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .borrows (borrows)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Borrow out of bit i is whether the low i+1 bits of a are smaller than b's plus bin.
    task automatic ref_sub(input int av, input int bv, input int bi,
                           output logic [W-1:0] d, output logic bo, output logic [W-1:0] br);
        int m;
        d  = W'(av - bv - bi);
        bo = (av < bv + bi);
        for (int i = 0; i < W; i++) begin
            m     = 1 << (i + 1);
            br[i] = ((av % m) < ((bv % m) + bi));
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                          input logic [W-1:0] ed, input logic eb, input logic [W-1:0] ebr,
                          input string nm);
        int lat;
        bit got;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, " busy_after_accept"}, busy, 1);
        lat = 0;
        got = 0;
        while (!got && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
            else chk({nm, " held_diff"}, {bout, borrows, diff}, {prev_bout, prev_brw, prev_diff});
        end
        chk({nm, " latency"}, lat, W);
        chk({nm, " diff"}, diff, ed);
        chk({nm, " bout"}, bout, eb);
        chk({nm, " borrows"}, borrows, ebr);
        chk({nm, " busy_in_done"}, busy, 1);
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, done, 0);
        chk({nm, " busy_falls"}, busy, 0);
        prev_diff = ed; prev_bout = eb; prev_brw = ebr;
    endtask

    initial begin
        logic [W-1:0] ed, ebr;
        logic         eb;
        int           ndone, cyc;
        logic [W-1:0] ra, rb;
        logic         rbi;

        vecs[0] = '{3'd5, 3'd3, 1'b0, 3'd2, 1'b0, 3'b010};
        vecs[1] = '{3'd3, 3'd5, 1'b0, 3'd6, 1'b1, 3'b100};
        vecs[2] = '{3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 3'b111};
        vecs[3] = '{3'd7, 3'd7, 1'b1, 3'd7, 1'b1, 3'b111};
        vecs[4] = '{3'd6, 3'd1, 1'b0, 3'd5, 1'b0, 3'b001};
        vecs[5] = '{3'd4, 3'd1, 1'b0, 3'd3, 1'b0, 3'b011};
        vecs[6] = '{3'd7, 3'd0, 1'b0, 3'd7, 1'b0, 3'b000};
        vecs[7] = '{3'd0, 3'd7, 1'b0, 3'd1, 1'b1, 3'b111};
        vecs[8] = '{3'd7, 3'd7, 1'b0, 3'd0, 1'b0, 3'b000};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev_diff = '0; prev_bout = 1'b0; prev_brw = '0;
        #1;
        chk("reset_outputs", {busy, done, bout, diff, borrows}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_release", {busy, done, bout, diff, borrows}, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].diff, vecs[i].bout, vecs[i].brw, $sformatf("vec%0d", i));
        end

        // Back-to-back with start held: done every W+2 cycles, busy low for one.
        @(negedge clk);
        a = 3'd7; b = 3'd7; bin = 1'b1; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b done k%0d", k), done, (k % (W + 2)) == W);
            chk($sformatf("b2b busy k%0d", k), busy, (k % (W + 2)) != W + 1);
            if ((k % (W + 2)) == W)
                chk($sformatf("b2b result k%0d", k), {bout, borrows, diff}, {1'b1, 3'b111, 3'd7});
        end
        @(negedge clk);
        start = 1'b0;
        prev_diff = 3'd7; prev_bout = 1'b1; prev_brw = 3'b111;

        // Inputs thrashed while busy must not disturb 6-1 or cause a second accept.
        @(negedge clk);
        a = 3'd6; b = 3'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("toggle busy_after_accept", busy, 1);
        ndone = 0;
        cyc = 0;
        while (busy && cyc < 12) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom); start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                ndone++;
                chk("toggle diff", diff, 3'd5);
                chk("toggle bout", bout, 0);
                chk("toggle borrows", borrows, 3'b001);
            end
        end
        chk("toggle busy_cycles", cyc, W + 1);
        chk("toggle done_count", ndone, 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("toggle no_extra_accept", busy, 0);
        prev_diff = 3'd5; prev_bout = 1'b0; prev_brw = 3'b001;

        for (int n = 0; n < 30; n++) begin
            ra  = W'($urandom_range(0, 7));
            rb  = W'($urandom_range(0, 7));
            rbi = 1'($urandom_range(0, 1));
            ref_sub(int'(ra), int'(rb), int'(rbi), ed, eb, ebr);
            run_op(ra, rb, rbi, ed, eb, ebr, $sformatf("rand%0d", n));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Leave nonzero results so the reset clearing is observable.
        run_op(3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 3'b111, "pre_reset");
        @(negedge clk);
        a = 3'd6; b = 3'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset outputs", {busy, done, bout, diff, borrows}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("midrun_reset quiet k%0d", k), {busy, done}, 0);
        end
        prev_diff = '0; prev_bout = 1'b0; prev_brw = '0;
        run_op(3'd4, 3'd1, 1'b0, 3'd3, 1'b0, 3'b011, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
